// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the multicycle RV32I core: one word RAM, a 16-byte MMIO window,
// and a boot loader FSM that streams the program image in while holding the core in reset.
module riscv_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FFF0,
  parameter int unsigned LED_W       = 8,
  // Reset value of the CYCLE counter; nonzero only to exercise the wrap without 2^32 cycles.
  parameter logic [31:0] CYCLE_INIT  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      Adr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  input  logic             load_valid,
  input  logic [31:0]      load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             cpu_reset,
  output logic [LED_W-1:0] led,
  output logic             halted,
  output logic             bus_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [AW-1:0]    load_ptr_reg;
  logic [LED_W-1:0] led_reg;
  logic [31:0]      cycle_cnt_reg;
  logic             halted_reg;
  logic             bus_err_reg;

  logic [31:0]      mem [DEPTH_WORDS];

  logic [AW-1:0]    word_idx;
  logic             is_ram;
  logic             is_mmio;
  logic [1:0]       mmio_off;
  logic             is_run;
  logic             load_xfer;
  logic             core_wr;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [31:0]      ram_wdata;
  logic [31:0]      mmio_rdata;
  logic             unused_adr_bits;

  assign word_idx        = Adr[AW+1:2];
  assign is_ram          = (Adr[31:AW+2] == '0);
  assign is_mmio         = (Adr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off        = Adr[3:2];
  assign is_run          = (state_reg == ST_RUN);
  assign unused_adr_bits = ^Adr[1:0];

  // No RAM writes while reset is held, even though the FSM already sits in LOAD.
  assign load_xfer = load_valid && load_ready && !reset;
  assign core_wr   = is_run && MemWrite;

  // One write port shared by the loader (LOAD) and the core (RUN).
  assign ram_we    = load_xfer || (core_wr && is_ram);
  assign ram_waddr = is_run ? word_idx : load_ptr_reg;
  assign ram_wdata = is_run ? WriteData : load_data;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      2'd0:    mmio_rdata[LED_W-1:0] = led_reg;
      2'd1:    mmio_rdata = cycle_cnt_reg;
      2'd2:    mmio_rdata[0] = halted_reg;
      default: mmio_rdata = '0;
    endcase
  end

  // Combinational read so the core's IR/data flops capture on the same edge.
  always_comb begin
    ReadData = '0;
    if (!is_run || is_ram) begin
      ReadData = mem[word_idx];
    end else if (is_mmio) begin
      ReadData = mmio_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_LOAD;
      load_ptr_reg  <= '0;
      led_reg       <= '0;
      cycle_cnt_reg <= CYCLE_INIT;
      halted_reg    <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (load_xfer) begin
            load_ptr_reg <= load_ptr_reg + 1'b1;
            if (load_last || (load_ptr_reg == AW'(DEPTH_WORDS - 1))) begin
              state_reg <= ST_START;
            end
          end
        end
        ST_START: begin
          state_reg <= ST_RUN;
        end
        ST_RUN: begin
          cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
          if (core_wr && is_mmio) begin
            if (mmio_off == 2'd0) led_reg <= WriteData[LED_W-1:0];
            if (mmio_off == 2'd2) halted_reg <= 1'b1;
          end
          // The address is always presented, so any unmapped cycle counts as an access.
          if (!is_ram && !is_mmio) begin
            bus_err_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_LOAD;
        end
      endcase
    end
  end

  assign load_ready = (state_reg == ST_LOAD);
  assign cpu_reset  = (state_reg != ST_RUN);
  assign led        = led_reg;
  assign halted     = halted_reg;
  assign bus_err    = bus_err_reg;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed bench: table of RUN-phase bus vectors plus hand-written load, reset and counter sequences.
module tb_riscv_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] MB    = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_w = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Adr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        cpu_reset;
  logic [7:0]  led;
  logic        halted;
  logic        bus_err;

  logic [31:0] Adr_w = 32'h0;
  logic [31:0] ReadData_w;
  logic        load_ready_w;
  logic        cpu_reset_w;
  logic [7:0]  led_w;
  logic        halted_w;
  logic        bus_err_w;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  riscv_mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB), .LED_W(8)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .ReadData(ReadData), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .cpu_reset(cpu_reset), .led(led), .halted(halted), .bus_err(bus_err)
  );

  // Small instance with the counter preset just below wrap.
  riscv_mem_responder #(.DEPTH_WORDS(4), .MMIO_BASE(MB), .LED_W(8), .CYCLE_INIT(32'hFFFF_FFFD)) dut_w (
    .clk(clk), .reset(reset_w), .MemWrite(1'b0), .Adr(Adr_w), .WriteData(32'h0),
    .ReadData(ReadData_w), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready_w), .cpu_reset(cpu_reset_w), .led(led_w), .halted(halted_w), .bus_err(bus_err_w)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  led;
    logic        halt;
    logic        err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // One core bus cycle; ReadData is sampled before the edge that performs any store.
  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    MemWrite  = we;
    Adr       = a;
    WriteData = wd;
    #1;
    rd = ReadData;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    Adr      = 32'h0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_load_ready", {31'b0, load_ready}, 32'd1);
    chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("rst_flags", {22'b0, led, halted, bus_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [7:0]  model_led;
    logic [31:0] wrap_exp [5];

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_0001, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0009, 32'h0,         32'h3333_0003, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h2222_0002, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, MB,            32'h1234_56A5, 32'h0000_0000, 8'hA5, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, MB,            32'h0,         32'h0000_00A5, 8'hA5, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, MB + 32'hC,    32'h0,         32'h0000_0000, 8'hA5, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, MB + 32'hC,    32'h0000_FFFF, 32'h0000_0000, 8'hA5, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, MB + 32'h8,    32'h0,         32'h0000_0000, 8'hA5, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_8000, 32'h0000_0055, 32'h0000_0000, 8'hA5, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_0001, 8'hA5, 1'b0, 1'b1};
    vecs[11] = '{1'b1, MB + 32'h8,    32'h0000_0001, 32'h0000_0000, 8'hA5, 1'b1, 1'b1};
    vecs[12] = '{1'b0, MB + 32'h8,    32'h0,         32'h0000_0001, 8'hA5, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_0007, 32'h0,         32'hDEAD_BEEF, 8'hA5, 1'b1, 1'b1};

    // Session A: reset state, 3-word load, RUN vectors, cycle counter.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_load_ready", {31'b0, load_ready}, 32'd1);
    chk("init_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("init_flags", {22'b0, led, halted, bus_err}, 32'd0);
    reset = 1'b0;
    // Core stores during LOAD must be ignored.
    MemWrite  = 1'b1;
    Adr       = MB;
    WriteData = 32'h0000_00FF;
    load_word(32'h1111_0001, 1'b0);
    load_word(32'h2222_0002, 1'b0);
    chk("load3_ready_mid", {31'b0, load_ready}, 32'd1);
    load_word(32'h3333_0003, 1'b1);
    chk("load3_ready_start", {31'b0, load_ready}, 32'd0);
    chk("load3_cpu_reset_start", {31'b0, cpu_reset}, 32'd1);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    Adr      = 32'h0;
    chk("load3_cpu_reset_run", {31'b0, cpu_reset}, 32'd0);
    chk("load3_led_ignored", {24'b0, led}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      bus(vecs[i].we, vecs[i].adr, vecs[i].wd, rd);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].rd);
      chk($sformatf("vec%0d_flags", i), {22'b0, led, halted, bus_err},
          {22'b0, vecs[i].led, vecs[i].halt, vecs[i].err});
    end

    @(negedge clk);
    Adr = MB + 32'h4;
    #1;
    c1 = ReadData;
    repeat (7) @(negedge clk);
    #1;
    c2 = ReadData;
    chk("cycle_delta7", c2 - c1, 32'd7);

    // Session B: full-depth load without load_last, then a store/load loop to LED and HALT.
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("full_ready_last", {31'b0, load_ready}, 32'd1);
      load_word(32'hA5A5_0000 | 32'(i), 1'b0);
    end
    chk("full_ready_start", {31'b0, load_ready}, 32'd0);
    chk("full_cpu_reset_start", {31'b0, cpu_reset}, 32'd1);
    load_valid = 1'b1;
    load_data  = 32'hDEAD_DEAD;
    @(posedge clk);
    #1;
    chk("full_cpu_reset_run", {31'b0, cpu_reset}, 32'd0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    bus(1'b0, 32'h0000_0000, 32'h0, rd);
    chk("full_nowrap_w0", rd, 32'hA5A5_0000);
    bus(1'b0, 32'h0000_03FC, 32'h0, rd);
    chk("full_w255", rd, 32'hA5A5_00FF);
    bus(1'b0, 32'h0000_0200, 32'h0, rd);
    chk("full_w128", rd, 32'hA5A5_0080);

    model_led = 8'h00;
    for (int i = 1; i <= 3; i++) begin
      bus(1'b1, MB, 32'(i * 17), rd);
      model_led = 8'(i * 17);
      bus(1'b0, MB, 32'h0, rd);
      chk($sformatf("prog_lw_led%0d", i), rd, {24'b0, model_led});
    end
    bus(1'b1, MB + 32'h8, 32'h0, rd);
    chk("prog_final", {22'b0, led, halted, bus_err}, {22'b0, model_led, 1'b1, 1'b0});

    // Session C: reset mid-load keeps already-loaded words.
    pulse_reset();
    load_word(32'h7777_0000, 1'b0);
    load_word(32'h7777_0001, 1'b0);
    pulse_reset();
    load_word(32'h8888_0000, 1'b1);
    @(posedge clk);
    #1;
    chk("midrst_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    bus(1'b0, 32'h0000_0000, 32'h0, rd);
    chk("midrst_w0", rd, 32'h8888_0000);
    bus(1'b0, 32'h0000_0004, 32'h0, rd);
    chk("midrst_w1", rd, 32'h7777_0001);
    bus(1'b0, 32'h0000_0008, 32'h0, rd);
    chk("midrst_w2", rd, 32'hA5A5_0002);

    // Counter wrap on the preset instance.
    wrap_exp[0] = 32'hFFFF_FFFD;
    wrap_exp[1] = 32'hFFFF_FFFE;
    wrap_exp[2] = 32'hFFFF_FFFF;
    wrap_exp[3] = 32'h0000_0000;
    wrap_exp[4] = 32'h0000_0001;
    @(negedge clk);
    reset_w = 1'b0;
    Adr_w   = MB + 32'h4;
    load_word(32'h0000_0013, 1'b1);
    @(posedge clk);
    #1;
    chk("wrap_cpu_reset", {31'b0, cpu_reset_w}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("wrap_cycle%0d", k), ReadData_w, wrap_exp[k]);
      @(posedge clk);
      #1;
    end
    chk("wrap_flags", {21'b0, load_ready_w, led_w, halted_w, bus_err_w}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
